// File: rtl/lcd_pkg.sv
// Shared definitions for the character LCD sequencer: state encoding,
// HD44780 init command bytes and DDRAM line base addresses.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_EHIGH     = 3'd4,
        ST_HOLD      = 3'd5,
        ST_WAIT      = 3'd6
    } lcd_state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_HOME     = 8'h02;

    // Set-DDRAM-address commands for the start of each display line.
    localparam logic [7:0] LCD_LINE0_BASE = 8'h80;
    localparam logic [7:0] LCD_LINE1_BASE = 8'hC0;

    localparam int INIT_LEN = 4;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

    // Clear and home need the long execution wait; everything else is short.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Timing tick generator: one-cycle pulse every TICK_CYCLES clocks.
// 'clear' restarts the count so a freshly entered state sees full ticks.
module lcd_tick_gen #(
    parameter int TICK_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] cnt;

    // Free-running 0..TICK_CYCLES-1 counter, restarted on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/lcd_ctrl.sv
// Character LCD port sequencer: runs the power-up init sequence, then
// writes one byte per req/ready handshake with HD44780 E-pulse timing.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PWRUP     | power-up settle wait before the first init command
// INIT_LOAD | load init command i onto the bus latches (1 cycle)
// IDLE      | init complete, ready for a core write
// SETUP     | rs/data stable, E low, 1 tick
// EHIGH     | E high for E_HIGH_TICKS
// HOLD      | E low, bus held, 1 tick
// WAIT      | LCD execution time (long for clear/home)
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int TICK_CYCLES    = 100,
    parameter int POWERUP_TICKS  = 15000,
    parameter int E_HIGH_TICKS   = 1,
    parameter int CMD_WAIT_TICKS = 40,
    parameter int CLR_WAIT_TICKS = 1640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);
    localparam int MAX_A     = (POWERUP_TICKS > CLR_WAIT_TICKS) ? POWERUP_TICKS : CLR_WAIT_TICKS;
    localparam int MAX_B     = (CMD_WAIT_TICKS > E_HIGH_TICKS) ? CMD_WAIT_TICKS : E_HIGH_TICKS;
    localparam int MAX_TICKS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    lcd_state_t       state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] span;
    logic             timed;
    logic             span_done;
    logic             tick;
    logic             state_chg;
    logic [1:0]       init_idx;

    assign state_chg = (state_nxt != state);
    assign lcd_rw    = 1'b0;

    lcd_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_chg),
        .tick  (tick)
    );

    // Number of ticks the current state lasts; untimed states never expire.
    always_comb begin
        span  = CNT_W'(1);
        timed = 1'b1;
        case (state)
            ST_PWRUP: span = CNT_W'(POWERUP_TICKS);
            ST_EHIGH: span = CNT_W'(E_HIGH_TICKS);
            ST_WAIT:  span = is_long_cmd(lcd_rs, lcd_data) ? CNT_W'(CLR_WAIT_TICKS)
                                                           : CNT_W'(CMD_WAIT_TICKS);
            ST_SETUP, ST_HOLD: span = CNT_W'(1);
            default:  timed = 1'b0;
        endcase
        span_done = timed && tick && (wait_cnt == span - CNT_W'(1));
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        lcd_e     = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (span_done) state_nxt = ST_INIT_LOAD;
            end
            ST_INIT_LOAD: begin
                state_nxt = ST_SETUP;
            end
            ST_IDLE: begin
                ready = init_done;
                if (req && init_done) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (span_done) state_nxt = ST_EHIGH;
            end
            ST_EHIGH: begin
                lcd_e = 1'b1;
                if (span_done) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (span_done) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (span_done) begin
                    if (init_done || (init_idx == 2'(INIT_LEN - 1))) state_nxt = ST_IDLE;
                    else                                              state_nxt = ST_INIT_LOAD;
                end
            end
            default: state_nxt = ST_PWRUP;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_PWRUP;
        else      state <= state_nxt;
    end

    // Tick counter within the current state; frozen while untimed so IDLE cannot wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_chg) begin
            wait_cnt <= '0;
        end else if (timed && tick) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Bus latches load only on the way into SETUP and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (state == ST_INIT_LOAD) begin
            lcd_rs   <= 1'b0;
            lcd_data <= init_rom(init_idx);
        end else if ((state == ST_IDLE) && req && init_done) begin
            lcd_rs   <= req_rs;
            lcd_data <= req_data;
        end
    end

    // Init progress: step through the ROM, flag completion after the last entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_idx  <= 2'd0;
            init_done <= 1'b0;
        end else if ((state == ST_WAIT) && span_done && !init_done) begin
            if (init_idx == 2'(INIT_LEN - 1)) init_done <= 1'b1;
            else                              init_idx  <= init_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: timeline model of init/write slots checked every cycle,
// plus hand-computed latency, pulse-width and byte-order expectations.
module tb_lcd_ctrl;
    localparam int T    = 1;
    localparam int PWR  = 20;
    localparam int EH   = 2;
    localparam int CMDW = 4;
    localparam int CLRW = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       ready, init_done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_init [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic [8:0] epq[$];
    logic [8:0] want[$];

    always #5 clk = ~clk;

    lcd_ctrl #(
        .TICK_CYCLES    (T),
        .POWERUP_TICKS  (PWR),
        .E_HIGH_TICKS   (EH),
        .CMD_WAIT_TICKS (CMDW),
        .CLR_WAIT_TICKS (CLRW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .ready     (ready),
        .init_done (init_done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT on each active edge.
    logic       cap_req, cap_rs;
    logic [7:0] cap_data;
    always @(posedge clk) begin
        cap_req  = req;
        cap_rs   = req_rs;
        cap_data = req_data;
    end

    // Timeline model: each write is a slot of (2+EH+wait)*T busy cycles,
    // E high during ticks 1..EH of the slot; init slots are separated by one load cycle.
    int         k, m_start, m_end, m_next, m_idx;
    bit         m_active, m_done, m_ready_prev, acc, exp_e, exp_ready;
    logic       m_rs;
    logic [7:0] m_data;

    function automatic int slot_len(input logic rs, input logic [7:0] d);
        int w;
        w = (!rs && (d == 8'h01 || d == 8'h02)) ? CLRW : CMDW;
        return (2 + EH + w) * T;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                k = 0; m_active = 0; m_done = 0; m_ready_prev = 0; m_idx = 0;
                m_next = PWR * T + 1; m_rs = 0; m_data = 8'h00;
                check("rst_ready", ready, 0);
                check("rst_init_done", init_done, 0);
                check("rst_e", lcd_e, 0);
                check("rst_rs", lcd_rs, 0);
                check("rst_data", lcd_data, 0);
            end else begin
                k = k + 1;
                acc = cap_req && m_ready_prev;
                if (m_active && k == m_end) begin
                    m_active = 0;
                    if (!m_done) begin
                        m_idx = m_idx + 1;
                        if (m_idx == 4) m_done = 1;
                        else            m_next = k + 1;
                    end
                end
                if (!m_active) begin
                    if (m_done && acc) begin
                        m_active = 1; m_start = k; m_rs = cap_rs; m_data = cap_data;
                        m_end = k + slot_len(cap_rs, cap_data);
                    end else if (!m_done && k == m_next) begin
                        m_active = 1; m_start = k; m_rs = 0; m_data = exp_init[m_idx];
                        m_end = k + slot_len(1'b0, exp_init[m_idx]);
                    end
                end
                exp_ready = m_done && !m_active;
                exp_e = m_active && (k >= m_start + T) && (k < m_start + T + EH * T);
                check("m_ready", ready, exp_ready);
                check("m_init_done", init_done, m_done);
                check("m_e", lcd_e, exp_e);
                check("m_rs", lcd_rs, m_rs);
                check("m_data", lcd_data, m_data);
                check("m_rw", lcd_rw, 0);
                m_ready_prev = exp_ready;
            end
        end
    end

    // E-pulse monitor: records the bus at each rising E and checks pulse width.
    logic mon_prev_e = 1'b0;
    int   mon_w = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_prev_e = 1'b0;
                mon_w = 0;
            end else begin
                if (lcd_e) begin
                    if (!mon_prev_e) epq.push_back({lcd_rs, lcd_data});
                    mon_w = mon_w + 1;
                end else if (mon_prev_e) begin
                    check("e_width", mon_w, EH * T);
                    mon_w = 0;
                end
                mon_prev_e = lcd_e;
            end
        end
    end

    task automatic check_pulses(input string name);
        logic [31:0] got;
        check(name, epq.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            got = (i < epq.size()) ? 32'(epq[i]) : 32'hDEAD;
            check(name, got, 32'(want[i]));
        end
        epq.delete();
        want.delete();
    endtask

    task automatic wait_ready(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!ready && n < max_cyc);
        check("ready_wait", ready, 1);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, output int low);
        int n;
        wait_ready(300, n);
        #1 req = 1'b1; req_rs = rs; req_data = d;
        @(posedge clk);
        #1 req = 1'b0; req_rs = ~rs; req_data = 8'hA5;
        low = 0;
        forever begin
            @(negedge clk);
            if (ready || low >= 300) break;
            low = low + 1;
        end
    endtask

    logic [7:0] b2b [3] = '{8'h34, 8'h2B, 8'h35};

    initial begin
        int n, low;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        wait_ready(300, n);
        check("init_cycles", n, 62);
        check("init_done_up", init_done, 1);
        for (int i = 0; i < 4; i++) want.push_back({1'b0, exp_init[i]});
        check_pulses("init_bytes");

        do_write(1'b1, 8'h34, low);
        check("lat_char", low, 8);
        want.push_back(9'h134);
        check_pulses("char_byte");

        do_write(1'b0, 8'h01, low);
        check("lat_clear", low, 14);
        do_write(1'b0, 8'h02, low);
        check("lat_home", low, 14);
        do_write(1'b0, 8'hC0, low);
        check("lat_line1", low, 8);
        want.push_back(9'h001); want.push_back(9'h002); want.push_back(9'h0C0);
        check_pulses("cmd_bytes");

        wait_ready(300, n);
        #1 req = 1'b1; req_rs = 1'b1; req_data = b2b[0];
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wait_ready(300, n);
            @(posedge clk);
            #1;
            if (i < 2) req_data = b2b[i + 1];
            else       req = 1'b0;
        end
        wait_ready(300, n);
        for (int i = 0; i < 3; i++) want.push_back({1'b1, b2b[i]});
        check_pulses("b2b_bytes");

        wait_ready(300, n);
        #1 req = 1'b1; req_rs = 1'b1; req_data = 8'h41;
        @(posedge clk);
        #1 req = 1'b0;
        n = 0;
        while (!lcd_e && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        check("e_before_rst", lcd_e, 1);
        #2 rst = 1'b0;
        #1;
        check("async_e", lcd_e, 0);
        check("async_ready", ready, 0);
        check("async_init_done", init_done, 0);
        check("async_data", lcd_data, 0);
        req = 1'b1; req_rs = 1'b1; req_data = 8'h42;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        epq.delete();

        wait_ready(300, n);
        check("reinit_cycles", n, 62);
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("early_req_taken", ready, 0);
        wait_ready(300, n);
        for (int i = 0; i < 4; i++) want.push_back({1'b0, exp_init[i]});
        want.push_back(9'h142);
        check_pulses("reinit_bytes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
